muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M multiply/divide resource used by the execute stage.
- Accepts one M-extension op at a time and runs a 32-iteration shift-add multiply or restoring divide.
- Holds the pipeline via a stall output until the result is ready.
- Handles RV32M corner cases: divide-by-zero and signed overflow.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - execute-stage request/result bundle for the RV32M multiply/divide sequencer
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              flush;
    logic              stall;
    logic              done;
    logic [XLEN-1:0]   result;
    logic [2*XLEN-1:0] mul_div_out;
    logic              busy;

    modport master (
        output req_valid, funct3, a, b, flush,
        input  stall, done, result, mul_div_out, busy
    );

    modport slave (
        input  req_valid, funct3, a, b, flush,
        output stall, done, result, mul_div_out, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M shift-add multiply / restoring divide sequencer; MULDIV_OPCACHE_EN adds a last-result cache
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic [2*XLEN-1:0] mdo_q, mdo_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              cache_load, cache_wr, cache_clr, cache_hit;
    logic [2*XLEN-1:0] cache_raw;

    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] f3, input logic [2*XLEN-1:0] raw);
        if (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd5) return raw[XLEN-1:0];
        return raw[2*XLEN-1:XLEN];
    endfunction

    logic              req_div, sgn_a, sgn_b, req_sa, req_sb, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] fast_raw;

    always_comb begin
        req_div  = bus.funct3[2];
        sgn_a    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                   (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        sgn_b    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        req_sa   = sgn_a & bus.a[XLEN-1];
        req_sb   = sgn_b & bus.b[XLEN-1];
        abs_a    = req_sa ? -bus.a : bus.a;
        abs_b    = req_sb ? -bus.b : bus.b;
        div_zero = req_div && (bus.b == '0);
        div_ovf  = req_div && sgn_a && (bus.a == MIN_NEG) && (bus.b == '1);
        fast_raw = div_zero ? {bus.a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_NEG};
    end

    // One iteration step for each engine; acc holds {hi, lo} = {partial, multiplier} or {rem, quo}.
    logic [XLEN:0]     mul_sum, trial;
    logic [2*XLEN-1:0] mul_next, div_next, fix_raw;
    logic [XLEN-1:0]   fix_quo, fix_rem;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        if (!trial[XLEN]) begin
            div_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc_q[2*XLEN-2:0], 1'b0};
        end
        fix_quo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        fix_rem = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            fix_raw = {fix_rem, fix_quo};
        end else begin
            fix_raw = neg_q ? -acc_q : acc_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        f3_d       = f3_q;
        neg_d      = neg_q;
        sa_d       = sa_q;
        mdo_d      = mdo_q;
        res_d      = res_q;
        cache_load = 1'b0;
        cache_wr   = 1'b0;
        cache_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    f3_d  = bus.funct3;
                    neg_d = req_sa ^ req_sb;
                    sa_d  = req_sa;
                    if (div_zero || div_ovf) begin
                        mdo_d   = fast_raw;
                        res_d   = sel_result(bus.funct3, fast_raw);
                        state_d = S_DONE;
                    end else if (cache_hit) begin
                        mdo_d   = cache_raw;
                        res_d   = sel_result(bus.funct3, cache_raw);
                        state_d = S_DONE;
                    end else begin
                        cnt_d      = CNT_W'(XLEN);
                        acc_d      = {{XLEN{1'b0}}, abs_a};
                        opb_d      = abs_b;
                        cache_load = 1'b1;
                        state_d    = req_div ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) begin
                    cache_clr = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    cache_clr = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mdo_d    = fix_raw;
                    res_d    = sel_result(f3_q, fix_raw);
                    cache_wr = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            mdo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            mdo_q   <= mdo_d;
            res_q   <= res_d;
        end
    end

`ifdef MULDIV_OPCACHE_EN
    // Key is captured at accept and marked valid only when that op completes, so a flushed op never hits.
    logic              cv_q, cv_d;
    logic [XLEN-1:0]   ca_q, ca_d, cb_q, cb_d;
    logic [1:0]        csgn_q, csgn_d;
    logic              cdiv_q, cdiv_d;
    logic [2*XLEN-1:0] craw_q, craw_d;

    always_comb begin
        cache_hit = cv_q && (bus.a == ca_q) && (bus.b == cb_q) && (req_div == cdiv_q) &&
                    ((!req_div && bus.funct3 == 3'd0) || (csgn_q == {sgn_a, sgn_b}));
        cache_raw = craw_q;
        cv_d      = cv_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        csgn_d    = csgn_q;
        cdiv_d    = cdiv_q;
        craw_d    = craw_q;
        if (cache_load) begin
            cv_d   = 1'b0;
            ca_d   = bus.a;
            cb_d   = bus.b;
            csgn_d = {sgn_a, sgn_b};
            cdiv_d = req_div;
        end
        if (cache_wr) begin
            cv_d   = 1'b1;
            craw_d = fix_raw;
        end
        if (cache_clr) cv_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q   <= 1'b0;
            ca_q   <= '0;
            cb_q   <= '0;
            csgn_q <= '0;
            cdiv_q <= 1'b0;
            craw_q <= '0;
        end else begin
            cv_q   <= cv_d;
            ca_q   <= ca_d;
            cb_q   <= cb_d;
            csgn_q <= csgn_d;
            cdiv_q <= cdiv_d;
            craw_q <= craw_d;
        end
    end
`else
    logic unused_cache;
    assign cache_hit    = 1'b0;
    assign cache_raw    = '0;
    assign unused_cache = cache_load ^ cache_wr ^ cache_clr;
`endif

    assign bus.done        = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.stall       = bus.req_valid & ~bus.done;
    assign bus.result      = res_q;
    assign bus.mul_div_out = mdo_q;

    // The execute stage must hold the op until done or flush.
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        ((state_q == S_MUL || state_q == S_DIV || state_q == S_FIX) && !bus.flush) |-> bus.req_valid);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - vector table, corner sequences and randomized checks for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int LAT_FULL = 34;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus();
    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [63:0] mdo;
        int          lat_nc;
        int          lat_c;
    } vec_t;

    vec_t        vecs[17];
    int          nvec = 0;
    int          nfail = 0;
    logic [63:0] last_mdo_exp = 64'd0;

    bit          m_cv = 1'b0;
    logic [31:0] m_ca, m_cb;
    logic [2:0]  m_cf3;
    logic [63:0] m_craw;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_raw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0, 3'd3: return ua * ub;
            3'd1:       return sa * sb;
            3'd2:       return sa * longint'(ub);
            3'd4, 3'd6: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_sel(input logic [2:0] f3, input logic [63:0] raw);
        return (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd5) ? raw[31:0] : raw[63:32];
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [1:0] sclass(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd4, 3'd6: return 2'b11;
            3'd2:             return 2'b10;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic bit m_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_OPCACHE_EN
        return m_cv && a == m_ca && b == m_cb && f3[2] == m_cf3[2] &&
               (f3 == 3'd0 || sclass(f3) == sclass(m_cf3));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_complete(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!is_fast(f3, a, b) && !m_hit(f3, a, b)) begin
            m_cv   = 1'b1;
            m_ca   = a;
            m_cb   = b;
            m_cf3  = f3;
            m_craw = ref_raw(f3, a, b);
        end
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge of the following idle cycle.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [63:0] exp_mdo, input int exp_lat);
        int lat, nstall;
        bit to;
        logic stall_done;
        bus.funct3    = f3;
        bus.a         = a;
        bus.b         = b;
        bus.req_valid = 1'b1;
        #1;
        lat = 0;
        nstall = 0;
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.stall) nstall++;
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
        end
        stall_done = bus.stall;
        check({name, " timeout"}, 64'(to), 64'd0);
        check({name, " result"}, 64'(bus.result), 64'(exp_res));
        check({name, " mul_div_out"}, bus.mul_div_out, exp_mdo);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " stall cycles"}, 64'(nstall), 64'(exp_lat));
        check({name, " stall at done"}, 64'(stall_done), 64'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check({name, " idle after done"}, 64'(bus.busy), 64'd0);
        last_mdo_exp = exp_mdo;
        model_complete(f3, a, b);
    endtask

    task automatic do_model_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] raw;
        bit hit;
        hit = m_hit(f3, a, b);
        raw = hit ? m_craw : ref_raw(f3, a, b);
        do_op(name, f3, a, b, ref_sel(f3, raw), raw, (hit || is_fast(f3, a, b)) ? 1 : LAT_FULL);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] ra, rb, pa, pb;
        bit          seen_done;
        int          lat;

        vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         64'h0000_0000_0000_002A, 34, 34};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34, 34};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 64'h0000_0001_FFFF_FFFE, 34, 34};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 34, 34};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1};
        vecs[5]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 64'h0000_0005_FFFF_FFFF, 1, 1};
        vecs[6]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_8000_0000, 1, 1};
        vecs[7]  = '{3'd4, 32'd100,        32'd7,          32'd14,         64'h0000_0002_0000_000E, 34, 34};
        vecs[8]  = '{3'd6, 32'd100,        32'd7,          32'd2,          64'h0000_0002_0000_000E, 34, 1};
        vecs[9]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34, 34};
        vecs[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 64'h4000_0000_0000_0000, 34, 34};
        vecs[11] = '{3'd5, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 34, 34};
        vecs[12] = '{3'd7, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F, 64'h0000_000F_0FFF_FFFF, 34, 34};
        vecs[13] = '{3'd4, 32'h8000_0000, 32'd2,          32'hC000_0000, 64'h0000_0000_C000_0000, 34, 34};
        vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 64'h4000_0000_0000_0000, 34, 34};
        vecs[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0001_FFFF_FFFD, 34, 34};
        vecs[16] = '{3'd7, 32'd0,          32'd0,          32'h0000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.funct3    = 3'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset mul_div_out", bus.mul_div_out, 64'd0);

        for (int i = 0; i < 17; i++) begin
`ifdef MULDIV_OPCACHE_EN
            lat = vecs[i].lat_c;
`else
            lat = vecs[i].lat_nc;
`endif
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].mdo, lat);
        end

        // Flush a DIV 10 cycles in: no done, outputs untouched, then a fresh MUL runs normally.
        bus.funct3    = 3'd4;
        bus.a         = 32'd100;
        bus.b         = 32'd3;
        bus.req_valid = 1'b1;
        seen_done     = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush mul_div_out held", bus.mul_div_out, last_mdo_exp);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        m_cv          = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("flush no done", 64'(seen_done), 64'd0);
        @(negedge clk);
        do_op("mul after flush", 3'd0, 32'd3, 32'd3, 32'd9, 64'd9, LAT_FULL);

        // A flushed request in IDLE is never accepted.
        bus.funct3    = 3'd0;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        check("idle flush busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;

        // Reset drops any cached result: the REM must take the full path.
        do_model_op("div before rst", 3'd4, 32'd100, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_cv = 1'b0;
        do_op("rem after rst", 3'd6, 32'd100, 32'd7, 32'd2, 64'h0000_0002_0000_000E, LAT_FULL);

        // Reset in the middle of a multiply returns every output to zero.
        bus.funct3    = 3'd0;
        bus.a         = 32'd5;
        bus.b         = 32'd5;
        bus.req_valid = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst busy", 64'(bus.busy), 64'd0);
        check("mid rst done", 64'(bus.done), 64'd0);
        check("mid rst stall", 64'(bus.stall), 64'd0);
        check("mid rst result", 64'(bus.result), 64'd0);
        check("mid rst mul_div_out", bus.mul_div_out, 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        m_cv = 1'b0;

        pa = 32'd12345;
        pb = 32'd67;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: begin ra = pa; rb = pb; end
                4: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_model_op($sformatf("rand%0d f3=%0d", i, f3), f3, ra, rb);
            pa = ra;
            pb = rb;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
